// File: rtl/gelu_pkg.sv
// Shared GELU datapath package.
// Holds the default lane width and lane count, the lane-vector type used by the GELU array
// and the result collector, and the collector's stream FSM state type.
package gelu_pkg;

  localparam int unsigned GELU_W         = 32;
  localparam int unsigned GELU_NUM_LANES = 32;

  // One GELU result vector, lane 0 in the least significant bits.
  typedef logic signed [GELU_NUM_LANES-1:0][GELU_W-1:0] gelu_vec_t;

  typedef enum logic {
    StEmpty,
    StStream
  } collect_state_e;

endpackage

// File: rtl/gelu_vec_fifo.sv
// Vector-slot FIFO for the GELU result collector.
// Stores whole lane vectors; the caller qualifies wr/rd, so a write into a full FIFO only
// occurs together with a pop. Slot storage is not reset.
// Ports:
//   clk, rst    clock, synchronous active-high reset (clears pointers and count)
//   wr, wr_data push a vector into the tail slot
//   rd          pop the head slot
//   rd_data     head slot contents
//   count       registered occupancy 0..DEPTH
//   count_next  occupancy after this cycle's write/pop
//   full        count == DEPTH
module gelu_vec_fifo #(
  parameter int unsigned VEC_W = 1024,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [VEC_W-1:0]           wr_data,
  input  logic                       rd,
  output logic [VEC_W-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(DEPTH+1)-1:0] count_next,
  output logic                       full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [VEC_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    count_d = count_q + CntW'(wr) - CntW'(rd);
  end

  // DEPTH is a power of two, so pointers wrap naturally at the top of their range.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data    = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign count_next = count_d;
  assign full       = (count_q == CntW'(DEPTH));

endmodule

// File: rtl/gelu_result_collector.sv
// GELU result collector: buffers whole GELU result vectors (no input backpressure) and
// streams each one out as NUM_LANES/OUT_LANES beats of OUT_LANES lanes, lane 0 first.
// Optional feature macro: GELU_COLLECT_DROPCNT_EN adds the drop_cnt output.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   vec_valid    input vector valid
//   vec_data     input vector, lane k at bits [k*W +: W]
//   almost_full  registered, high when occupancy >= DEPTH-SLACK
//   m_valid      output beat valid
//   m_ready      downstream accepts the beat
//   m_data       output beat, lane j at bits [j*W +: W]; zero while idle
//   m_last       final beat of the current vector
//   overflow     sticky: a vector arrived while full and was dropped
//   drop_cnt     (macro only) saturating count of dropped vectors
module gelu_result_collector
  import gelu_pkg::*;
#(
  parameter int unsigned W         = GELU_W,
  parameter int unsigned NUM_LANES = GELU_NUM_LANES,
  parameter int unsigned OUT_LANES = 4,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned SLACK     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vec_valid,
  input  logic [NUM_LANES*W-1:0]   vec_data,
  output logic                     almost_full,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [OUT_LANES*W-1:0]   m_data,
  output logic                     m_last,
  output logic                     overflow
`ifdef GELU_COLLECT_DROPCNT_EN
  ,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int unsigned BEATS = NUM_LANES / OUT_LANES;
  localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);

  collect_state_e state_q, state_d;
  logic [BeatW-1:0]       beat_q, beat_d;
  logic                   almost_full_q, overflow_q;
  logic                   wr, pop, drop, accept;
  logic                   fifo_full;
  logic [CntW-1:0]        count, count_next;
  logic [NUM_LANES*W-1:0] head_data;

  assign accept = m_valid & m_ready;
  assign pop    = accept & m_last;
  // A full FIFO still takes a vector when the head leaves in the same cycle.
  assign wr     = vec_valid & ~rst & (~fifo_full | pop);
  assign drop   = vec_valid & ~rst & fifo_full & ~pop;

  gelu_vec_fifo #(
    .VEC_W (NUM_LANES * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr),
    .wr_data    (vec_data),
    .rd         (pop),
    .rd_data    (head_data),
    .count      (count),
    .count_next (count_next),
    .full       (fifo_full)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty:  if (wr) state_d = StStream;
      StStream: if (pop && !wr && count == CntW'(1)) state_d = StEmpty;
      default:  state_d = StEmpty;
    endcase
  end

  always_comb begin
    beat_d = beat_q;
    if (accept) beat_d = (beat_q == LastBeat) ? '0 : beat_q + 1'b1;
  end

  always_comb begin
    m_valid = (state_q == StStream);
    m_last  = m_valid & (beat_q == LastBeat);
    m_data  = '0;
    if (m_valid) m_data = head_data[int'(beat_q) * OUT_LANES * W +: OUT_LANES * W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StEmpty;
      beat_q        <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      almost_full_q <= (32'(count_next) >= (DEPTH - SLACK));
      overflow_q    <= overflow_q | drop;
    end
  end

  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;

`ifdef GELU_COLLECT_DROPCNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (drop && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_gelu_result_collector.sv
module tb_gelu_result_collector;

  localparam int W         = 32;
  localparam int NUM_LANES = 32;
  localparam int OUT_LANES = 4;
  localparam int BEATS     = NUM_LANES / OUT_LANES;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         vec_valid;
  logic [NUM_LANES*W-1:0]       vec_data;
  logic                         almost_full;
  logic                         m_valid;
  logic                         m_ready;
  logic [OUT_LANES*W-1:0]       m_data;
  logic                         m_last;
  logic                         overflow;
`ifdef GELU_COLLECT_DROPCNT_EN
  logic [15:0]                  drop_cnt;
`endif

  gelu_result_collector #(
    .W         (W),
    .NUM_LANES (NUM_LANES),
    .OUT_LANES (OUT_LANES),
    .DEPTH     (4),
    .SLACK     (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vec_valid   (vec_valid),
    .vec_data    (vec_data),
    .almost_full (almost_full),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .overflow    (overflow)
`ifdef GELU_COLLECT_DROPCNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_LANES*W-1:0] data;
    logic                   last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    accepts = 0;
  logic  hold_pending = 1'b0;
  logic [OUT_LANES*W-1:0] held_data;
  logic  held_last;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Lane k of a vector built from base holds base + k.
  function automatic logic [OUT_LANES*W-1:0] mkbeat(input int base, input int b);
    logic [OUT_LANES*W-1:0] r;
    for (int j = 0; j < OUT_LANES; j++) r[j*W +: W] = base + b * OUT_LANES + j;
    return r;
  endfunction

  function automatic logic [NUM_LANES*W-1:0] mkvec(input int base);
    logic [NUM_LANES*W-1:0] r;
    for (int k = 0; k < NUM_LANES; k++) r[k*W +: W] = base + k;
    return r;
  endfunction

  task automatic push_exp(input int base);
    beat_t e;
    for (int b = 0; b < BEATS; b++) begin
      e.data = mkbeat(base, b);
      e.last = (b == BEATS - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int bound, output int n);
    n = 0;
    while (n < bound && !(exp_q.size() == 0 && !m_valid)) begin
      tick();
      n++;
    end
    check(name, 128'(exp_q.size()), 128'd0);
  endtask

  // Monitor: the handshake seen at a negedge is the one the next posedge completes.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      hold_pending = 1'b0;
    end else if (m_valid) begin
      if (hold_pending) begin
        check("stall_hold_data", 128'(m_data), 128'(held_data));
        check("stall_hold_last", 128'(m_last), 128'(held_last));
      end
      if (m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 128'(m_data), 128'd0);
          if (m_data == '0) check("unexpected_beat_valid", 128'(m_valid), 128'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 128'(m_data), 128'(e.data));
          check("beat_last", 128'(m_last), 128'(e.last));
        end
        accepts++;
        hold_pending = 1'b0;
      end else begin
        hold_pending = 1'b1;
        held_data    = m_data;
        held_last    = m_last;
      end
    end else begin
      if (hold_pending) check("valid_dropped_in_stall", 128'(m_valid), 128'd1);
      hold_pending = 1'b0;
      check("idle_data_zero", 128'(m_data), 128'd0);
      check("idle_last_zero", 128'(m_last), 128'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int start;
    rst       = 1'b1;
    vec_valid = 1'b0;
    vec_data  = '0;
    m_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_m_valid", 128'(m_valid), 128'd0);
    check("rst_m_last", 128'(m_last), 128'd0);
    check("rst_m_data", 128'(m_data), 128'd0);
    check("rst_almost_full", 128'(almost_full), 128'd0);
    check("rst_overflow", 128'(overflow), 128'd0);

    // One vector, lane k = k, always ready
    m_ready   = 1'b1;
    vec_valid = 1'b1;
    vec_data  = mkvec(0);
    push_exp(0);
    check("pre_latency_valid", 128'(m_valid), 128'd0);
    tick();
    vec_valid = 1'b0;
    check("latency_valid", 128'(m_valid), 128'd1);
    check("first_beat", 128'(m_data), {32'd3, 32'd2, 32'd1, 32'd0});
    check("first_beat_last", 128'(m_last), 128'd0);
    wait_drain("drain_t1", 20, n);
    check("t1_consecutive_cycles", 128'(n), 128'd8);

    // Ready toggling 1,0,1,0
    start     = accepts;
    m_ready   = 1'b0;
    vec_valid = 1'b1;
    vec_data  = mkvec(1000);
    push_exp(1000);
    tick();
    vec_valid = 1'b0;
    n = 0;
    while (n < 40 && !(exp_q.size() == 0 && !m_valid)) begin
      m_ready = ~m_ready;
      tick();
      n++;
    end
    check("t2_drained", 128'(exp_q.size()), 128'd0);
    check("t2_accepts", 128'(accepts - start), 128'd8);

    // Fill four slots with no pops; the third is negative to exercise sign passthrough
    m_ready   = 1'b0;
    vec_valid = 1'b1;
    vec_data  = mkvec(2000);
    push_exp(2000);
    tick();
    check("af_after_1st", 128'(almost_full), 128'd0);
    vec_data = mkvec(3000);
    push_exp(3000);
    tick();
    check("af_after_2nd", 128'(almost_full), 128'd1);
    vec_data = mkvec(-4000);
    push_exp(-4000);
    tick();
    vec_data = mkvec(5000);
    push_exp(5000);
    tick();
    vec_valid = 1'b0;
    check("fill_overflow", 128'(overflow), 128'd0);
    check("fill_af", 128'(almost_full), 128'd1);

    // Full, new vector on the same cycle as the last-beat accept
    m_ready = 1'b1;
    repeat (7) tick();
    check("at_last_beat", 128'(m_last), 128'd1);
    vec_valid = 1'b1;
    vec_data  = mkvec(7000);
    push_exp(7000);
    tick();
    vec_valid = 1'b0;
    m_ready   = 1'b0;
    check("swap_overflow", 128'(overflow), 128'd0);
    check("swap_af", 128'(almost_full), 128'd1);

    // Still full (count stayed 4): this vector must be dropped
    vec_valid = 1'b1;
    vec_data  = mkvec(6000);
    tick();
    vec_valid = 1'b0;
    check("drop_overflow", 128'(overflow), 128'd1);
`ifdef GELU_COLLECT_DROPCNT_EN
    check("drop_cnt", 128'(drop_cnt), 128'd1);
`endif
    tick();
    tick();
    check("overflow_sticky", 128'(overflow), 128'd1);
    m_ready = 1'b1;
    wait_drain("drain_full", 80, n);
    check("drained_af", 128'(almost_full), 128'd0);
    check("drained_overflow_sticky", 128'(overflow), 128'd1);

    // Reset during beat 3 of the second vector; vec_valid during reset is ignored
    start     = accepts;
    vec_valid = 1'b1;
    vec_data  = mkvec(8000);
    push_exp(8000);
    tick();
    vec_data = mkvec(9000);
    push_exp(9000);
    tick();
    vec_valid = 1'b0;
    n = 0;
    while (n < 30 && accepts < start + 11) begin
      tick();
      n++;
    end
    check("reach_beat3", 128'(accepts - start), 128'd11);
    check("beat3_data", 128'(m_data), 128'(mkbeat(9000, 3)));
    rst       = 1'b1;
    vec_valid = 1'b1;
    vec_data  = mkvec(9999);
    tick();
    rst       = 1'b0;
    vec_valid = 1'b0;
    exp_q.delete();
    check("post_rst_valid", 128'(m_valid), 128'd0);
    check("post_rst_af", 128'(almost_full), 128'd0);
    check("post_rst_overflow", 128'(overflow), 128'd0);
    check("post_rst_data", 128'(m_data), 128'd0);
`ifdef GELU_COLLECT_DROPCNT_EN
    check("post_rst_drop_cnt", 128'(drop_cnt), 128'd0);
`endif
    tick();
    check("rst_vec_ignored", 128'(m_valid), 128'd0);

    start     = accepts;
    vec_valid = 1'b1;
    vec_data  = mkvec(10000);
    push_exp(10000);
    tick();
    vec_valid = 1'b0;
    check("new_vec_beat0", 128'(m_data), 128'(mkbeat(10000, 0)));
    wait_drain("drain_after_rst", 20, n);
    check("after_rst_accepts", 128'(accepts - start), 128'd8);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
